// File: rtl/ins_sequencer_pkg.sv
// ins_seq_pkg: shared definitions for the instruction sequencer.
//   - 4-bit opcode encodings of the teaching CPU
//   - bit positions of the 16-bit one-hot operation vector
//   - FSM state enum
//   - op_steps(): number of execute cycles for a decoded operation
package ins_seq_pkg;

  // Opcode field encodings (ir[IR_W-1:IR_W-4])
  localparam logic [3:0] OPC_MOV   = 4'b1100;
  localparam logic [3:0] OPC_ADD   = 4'b1001;
  localparam logic [3:0] OPC_SUB   = 4'b0110;
  localparam logic [3:0] OPC_AND   = 4'b1011;
  localparam logic [3:0] OPC_NOT   = 4'b0101;
  localparam logic [3:0] OPC_SHIFT = 4'b1010;
  localparam logic [3:0] OPC_JUMP  = 4'b0011;
  localparam logic [3:0] OPC_IN    = 4'b0010;
  localparam logic [3:0] OPC_OUT   = 4'b0100;
  localparam logic [3:0] OPC_NOP   = 4'b0111;
  localparam logic [3:0] OPC_HALT  = 4'b1000;

  // Bit positions inside the one-hot operation vector
  localparam logic [3:0] OP_MOVA = 4'd0;
  localparam logic [3:0] OP_MOVB = 4'd1;
  localparam logic [3:0] OP_MOVC = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_RSR  = 4'd7;
  localparam logic [3:0] OP_RSL  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_JZ   = 4'd10;
  localparam logic [3:0] OP_JC   = 4'd11;
  localparam logic [3:0] OP_IN   = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Operations that occupy the datapath for ALU_STEPS cycles:
  // add, sub, and, not, rsr, rsl (bits 3..8) and in, out (bits 12, 13).
  localparam logic [15:0] MULTI_STEP_MASK = 16'h31F8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  // Execute-cycle count of a decoded operation; everything outside the
  // multi-step class completes in a single cycle.
  function automatic logic [2:0] op_steps(input logic [15:0] op, input int alu_steps);
    logic [2:0] n;
    if ((op & MULTI_STEP_MASK) != 16'd0) begin
      n = alu_steps[2:0];
    end else begin
      n = 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ins_sequencer_if.sv
// ins_sequencer_if: handshake, flag and control bundle between the
// fetch/datapath side (master) and the instruction sequencer (slave).
//   en        stall control, low freezes the sequencer
//   ir_valid  instruction word valid
//   ir        instruction word (IR_W bits)
//   ir_ready  sequencer can accept a word this cycle
//   zf, cf    datapath zero / carry flags
//   op        one-hot operation, 0 when idle
//   step      current execute step
//   done      last execute step of the instruction
//   pc_load   last step of a taken jump
//   halted    sticky halt indicator
//   illegal   unassigned opcode seen in DECODE
interface ins_sequencer_if #(parameter int IR_W = 8) ();
  logic            en;
  logic            ir_valid;
  logic [IR_W-1:0] ir;
  logic            ir_ready;
  logic            zf;
  logic            cf;
  logic [15:0]     op;
  logic [2:0]      step;
  logic            done;
  logic            pc_load;
  logic            halted;
  logic            illegal;

  modport master (
    output en, ir_valid, ir, zf, cf,
    input  ir_ready, op, step, done, pc_load, halted, illegal
  );

  modport slave (
    input  en, ir_valid, ir, zf, cf,
    output ir_ready, op, step, done, pc_load, halted, illegal
  );
endinterface

// File: rtl/ins_sequencer_opdec.sv
// ins_opdec: combinational opcode decoder.
//   opcode_i   4-bit opcode field
//   sub_i      4-bit sub-field
//   op_o       16-bit operation vector (one-hot, except jump sub-field 11
//              which sets both jz and jc)
//   illegal_o  opcode is unassigned; op_o then reports nop
module ins_opdec
  import ins_seq_pkg::*;
(
  input  logic [3:0]  opcode_i,
  input  logic [3:0]  sub_i,
  output logic [15:0] op_o,
  output logic        illegal_o
);

  // Opcode / sub-field to operation vector
  always_comb begin
    op_o      = 16'd0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_MOV: begin
        // movb has priority over movc when both sub-field pairs are set
        if (sub_i[3] & sub_i[2]) begin
          op_o[OP_MOVB] = 1'b1;
        end else if (sub_i[1] & sub_i[0]) begin
          op_o[OP_MOVC] = 1'b1;
        end else begin
          op_o[OP_MOVA] = 1'b1;
        end
      end
      OPC_ADD: op_o[OP_ADD] = 1'b1;
      OPC_SUB: op_o[OP_SUB] = 1'b1;
      OPC_AND: op_o[OP_AND] = 1'b1;
      OPC_NOT: op_o[OP_NOT] = 1'b1;
      OPC_SHIFT: begin
        if (sub_i[1:0] == 2'b00) begin
          op_o[OP_RSR] = 1'b1;
        end else begin
          op_o[OP_RSL] = 1'b1;
        end
      end
      OPC_JUMP: begin
        case (sub_i[1:0])
          2'b00: op_o[OP_JMP] = 1'b1;
          2'b01: op_o[OP_JZ]  = 1'b1;
          2'b10: op_o[OP_JC]  = 1'b1;
          2'b11: begin
            // jump on zero-or-carry: both condition bits raised together
            op_o[OP_JZ] = 1'b1;
            op_o[OP_JC] = 1'b1;
          end
          default: op_o[OP_NOP] = 1'b1;
        endcase
      end
      OPC_IN:   op_o[OP_IN]   = 1'b1;
      OPC_OUT:  op_o[OP_OUT]  = 1'b1;
      OPC_NOP:  op_o[OP_NOP]  = 1'b1;
      OPC_HALT: op_o[OP_HALT] = 1'b1;
      default: begin
        op_o[OP_NOP] = 1'b1;
        illegal_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ins_sequencer.sv
// ins_sequencer: registered multi-cycle instruction decoder and control
// sequencer. Accepts one word per ir_valid/ir_ready handshake, walks
// IDLE -> DECODE -> EXEC (N steps) -> IDLE, or parks in HALT.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ins_sequencer_if.slave (handshake, flags, control outputs)
// op and illegal are decoded from the captured word and the state
// register, so they are available from the DECODE cycle onward.
module ins_sequencer
  import ins_seq_pkg::*;
#(
  parameter int IR_W      = 8,
  parameter int ALU_STEPS = 2
) (
  input  logic            clk,
  input  logic            rst,
  ins_sequencer_if.slave  bus
);

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [2:0]      step_q, step_d;
  logic            taken_q, taken_d;
  logic            done_q, done_d;
  logic            pc_load_q, pc_load_d;
  logic            halted_q, halted_d;

  logic [15:0]     dec_op;
  logic            dec_illegal;
  logic [2:0]      last_step;
  logic            flag_taken;

  ins_opdec u_opdec (
    .opcode_i  (ir_q[IR_W-1 -: 4]),
    .sub_i     (ir_q[3:0]),
    .op_o      (dec_op),
    .illegal_o (dec_illegal)
  );

  assign last_step  = op_steps(dec_op, ALU_STEPS) - 3'd1;
  // Jump condition from the live flags; only latched while in DECODE.
  assign flag_taken = dec_op[OP_JMP] | (dec_op[OP_JZ] & bus.zf) | (dec_op[OP_JC] & bus.cf);

  // Next-state, step counter and next value of the pulsed outputs
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    step_d    = step_q;
    taken_d   = taken_q;
    done_d    = done_q;
    pc_load_d = pc_load_q;
    halted_d  = halted_q;
    if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ir_valid) begin
            state_d = ST_DECODE;
            ir_d    = bus.ir;
          end else begin
            state_d = ST_IDLE;
          end
          step_d = 3'd0;
        end
        ST_DECODE: begin
          state_d = ST_EXEC;
          step_d  = 3'd0;
          taken_d = flag_taken;
        end
        ST_EXEC: begin
          if (step_q == last_step) begin
            state_d = dec_op[OP_HALT] ? ST_HALT : ST_IDLE;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
          step_d  = 3'd0;
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = 3'd0;
        end
      endcase
      // Pulses are computed for the cycle being entered, so a stall that
      // lands on the last step keeps them up until the step completes.
      done_d    = (state_d == ST_EXEC) && (step_d == last_step);
      pc_load_d = done_d & taken_d;
      halted_d  = (state_d == ST_HALT);
    end else begin
      state_d = state_q;
    end
  end

  // State, captured word and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= {IR_W{1'b0}};
      step_q    <= 3'd0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      step_q    <= step_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
      pc_load_q <= pc_load_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.ir_ready = (state_q == ST_IDLE) & bus.en;
  assign bus.op       = (state_q == ST_IDLE) ? 16'd0 : dec_op;
  assign bus.illegal  = (state_q == ST_DECODE) & dec_illegal;
  assign bus.step     = step_q;
  assign bus.done     = done_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_ins_sequencer.sv
// Testbench for ins_sequencer: vector table, hand-written corner
// sequences (halt, stall, reset abort) and randomized instructions with
// random stalls checked against a transaction-level model.
module tb_ins_sequencer;
  localparam int ALU_N = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ins_sequencer_if #(.IR_W(8)) bus ();

  ins_sequencer #(.IR_W(8), .ALU_STEPS(ALU_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ir;
    logic        zf;
    logic        cf;
    logic [15:0] exp_op;
    int          exp_n;
    logic        exp_pcl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_op, input logic [2:0] e_step,
                           input logic e_done, input logic e_pcl, input logic e_ill,
                           input logic e_rdy, input logic e_halt);
    chk({tag, ".op"},       32'(bus.op),       32'(e_op));
    chk({tag, ".step"},     32'(bus.step),     32'(e_step));
    chk({tag, ".done"},     32'(bus.done),     32'(e_done));
    chk({tag, ".pc_load"},  32'(bus.pc_load),  32'(e_pcl));
    chk({tag, ".illegal"},  32'(bus.illegal),  32'(e_ill));
    chk({tag, ".ir_ready"}, 32'(bus.ir_ready), 32'(e_rdy));
    chk({tag, ".halted"},   32'(bus.halted),   32'(e_halt));
  endtask

  // Transaction-level decode model: operation index (or two for jz+jc),
  // step count and illegal flag straight from the opcode table.
  function automatic void model_decode(input logic [7:0] w, output logic [15:0] o,
                                       output int n, output logic ill);
    int idx;
    int idx2;
    ill  = 1'b0;
    idx2 = -1;
    case (w[7:4])
      4'hC: idx = (w[3] && w[2]) ? 1 : ((w[1] && w[0]) ? 2 : 0);
      4'h9: idx = 3;
      4'h6: idx = 4;
      4'hB: idx = 5;
      4'h5: idx = 6;
      4'hA: idx = (w[1:0] == 2'b00) ? 7 : 8;
      4'h3: begin
        if (w[1:0] == 2'b11) begin
          idx  = 10;
          idx2 = 11;
        end else begin
          idx = 9 + int'(w[1:0]);
        end
      end
      4'h2: idx = 12;
      4'h4: idx = 13;
      4'h7: idx = 14;
      4'h8: idx = 15;
      default: begin
        idx = 14;
        ill = 1'b1;
      end
    endcase
    o = 16'd1 << idx;
    if (idx2 >= 0) o = o | (16'd1 << idx2);
    n = ((idx >= 3 && idx <= 8) || idx == 12 || idx == 13) ? ALU_N : 1;
  endfunction

  // One table vector: flags as given in DECODE, inverted during EXEC,
  // and a junk word offered while busy.
  task automatic run_vec(input vec_t v);
    bus.en = 1'b1; bus.ir_valid = 1'b1; bus.ir = v.ir; bus.zf = ~v.zf; bus.cf = ~v.cf;
    #1;
    chk("vec.accept_ready", 32'(bus.ir_ready), 32'd1);
    tick();
    bus.ir = ~v.ir; bus.zf = v.zf; bus.cf = v.cf;
    #1;
    check_all($sformatf("vec%02h.decode", v.ir), v.exp_op, 3'd0, 1'b0, 1'b0, v.exp_ill, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < v.exp_n; k++) begin
      bus.zf = ~v.zf; bus.cf = ~v.cf;
      bus.ir_valid = (k != v.exp_n - 1);
      #1;
      check_all($sformatf("vec%02h.exec%0d", v.ir, k), v.exp_op, 3'(k), (k == v.exp_n - 1),
                (k == v.exp_n - 1) && v.exp_pcl, 1'b0, 1'b0, 1'b0);
      tick();
    end
    bus.ir_valid = 1'b0;
    #1;
    check_all($sformatf("vec%02h.idle", v.ir), 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b1; bus.ir_valid = 1'b0; bus.ir = 8'h00; bus.zf = 1'b0; bus.cf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Watchdog: the run is bounded well before this fires.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] e_op;
    int          n;
    int          p;
    int          tries;
    int          guard;
    logic        e_ill;
    logic        taken;
    logic        en_b;
    logic        accepted;

    checks = 0;
    failures = 0;

    vecs.push_back('{8'h90, 1'b0, 1'b0, 16'h0008, 2, 1'b0, 1'b0});
    vecs.push_back('{8'h60, 1'b0, 1'b0, 16'h0010, 2, 1'b0, 1'b0});
    vecs.push_back('{8'hB0, 1'b1, 1'b1, 16'h0020, 2, 1'b0, 1'b0});
    vecs.push_back('{8'h50, 1'b0, 1'b0, 16'h0040, 2, 1'b0, 1'b0});
    vecs.push_back('{8'hA0, 1'b0, 1'b0, 16'h0080, 2, 1'b0, 1'b0});
    vecs.push_back('{8'hA1, 1'b0, 1'b0, 16'h0100, 2, 1'b0, 1'b0});
    vecs.push_back('{8'h30, 1'b0, 1'b0, 16'h0200, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h31, 1'b1, 1'b0, 16'h0400, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h31, 1'b0, 1'b1, 16'h0400, 1, 1'b0, 1'b0});
    vecs.push_back('{8'h32, 1'b0, 1'b1, 16'h0800, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h32, 1'b1, 1'b0, 16'h0800, 1, 1'b0, 1'b0});
    vecs.push_back('{8'h33, 1'b0, 1'b1, 16'h0C00, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h33, 1'b1, 1'b0, 16'h0C00, 1, 1'b1, 1'b0});
    vecs.push_back('{8'h33, 1'b0, 1'b0, 16'h0C00, 1, 1'b0, 1'b0});
    vecs.push_back('{8'h20, 1'b0, 1'b0, 16'h1000, 2, 1'b0, 1'b0});
    vecs.push_back('{8'h40, 1'b0, 1'b0, 16'h2000, 2, 1'b0, 1'b0});
    vecs.push_back('{8'h70, 1'b0, 1'b0, 16'h4000, 1, 1'b0, 1'b0});
    vecs.push_back('{8'hC3, 1'b0, 1'b0, 16'h0004, 1, 1'b0, 1'b0});
    vecs.push_back('{8'hCC, 1'b0, 1'b0, 16'h0002, 1, 1'b0, 1'b0});
    vecs.push_back('{8'hCF, 1'b0, 1'b0, 16'h0002, 1, 1'b0, 1'b0});
    vecs.push_back('{8'hC0, 1'b0, 1'b0, 16'h0001, 1, 1'b0, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h4000, 1, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 16'h4000, 1, 1'b0, 1'b1});

    // Reset values
    do_reset();
    #1;
    check_all("reset", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b0;
    #1;
    chk("reset.ready_en_low", 32'(bus.ir_ready), 32'd0);
    bus.en = 1'b1;
    tick();

    // Vector table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall of 3 cycles in step 0 of an add: done moves 3 cycles later
    bus.en = 1'b1; bus.ir_valid = 1'b1; bus.ir = 8'h90;
    #1; chk("stall.accept", 32'(bus.ir_ready), 32'd1); tick();
    bus.ir_valid = 1'b0;
    #1; check_all("stall.decode", 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      bus.en = 1'b0;
      #1; check_all($sformatf("stall.hold%0d", c), 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    bus.en = 1'b1;
    #1; check_all("stall.step0", 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    #1; check_all("stall.step1", 16'h0008, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    #1; check_all("stall.idle", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Reset during step 0 of an add aborts it without done
    bus.ir_valid = 1'b1; bus.ir = 8'h90;
    #1; tick();
    bus.ir_valid = 1'b0;
    #1; tick();
    rst = 1'b1;
    #1; check_all("abort.step0", 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    #1; check_all("abort.idle", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    #1; check_all("abort.idle2", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Halt: sticky, ignores further words, cleared only by reset
    bus.ir_valid = 1'b1; bus.ir = 8'h80;
    #1; tick();
    bus.ir = 8'h90;
    #1; check_all("halt.decode", 16'h8000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    #1; check_all("halt.exec", 16'h8000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 5; c++) begin
      #1; check_all($sformatf("halt.park%0d", c), 16'h8000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end
    do_reset();
    #1; check_all("halt.reset", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Randomized instructions with random stalls and flag noise
    for (int t = 0; t < 80; t++) begin
      do begin
        w = 8'($urandom_range(0, 255));
      end while (w[7:4] == 4'h8);
      model_decode(w, e_op, n, e_ill);
      accepted = 1'b0;
      tries = 0;
      while (!accepted) begin
        en_b = (tries >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.en = en_b; bus.ir_valid = 1'b1; bus.ir = w;
        bus.zf = 1'($urandom); bus.cf = 1'($urandom);
        #1;
        chk("rnd.ready", 32'(bus.ir_ready), 32'(en_b));
        chk("rnd.idle_op", 32'(bus.op), 32'd0);
        tick();
        accepted = en_b;
        tries++;
      end
      p = 1;
      taken = 1'b0;
      guard = 0;
      while (p <= n + 1) begin
        en_b = (guard >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
        bus.en = en_b;
        bus.zf = 1'($urandom); bus.cf = 1'($urandom);
        bus.ir_valid = 1'($urandom); bus.ir = 8'($urandom);
        #1;
        check_all($sformatf("rnd%0d_%02h.p%0d", t, w, p), e_op, 3'((p >= 2) ? p - 2 : 0),
                  (p == n + 1), (p == n + 1) && taken, (p == 1) && e_ill, 1'b0, 1'b0);
        if (p == 1 && en_b) taken = e_op[9] | (e_op[10] & bus.zf) | (e_op[11] & bus.cf);
        tick();
        if (en_b) p++;
        guard++;
      end
      bus.en = 1'b1; bus.ir_valid = 1'b0;
      #1;
      check_all($sformatf("rnd%0d.idle", t), 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
